// File: rtl/fft_pkg.sv
// Shared FFT-pipeline definitions: lane count and bit-reversal helper.
// Latency: n/a (package). Backpressure: n/a.
// Reused by topfft and every downstream stage that needs natural-order indexing.
package fft_pkg;

  localparam int LANES = 4;

  // Reverse the low log2n bits of x; bits above log2n come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int log2n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < log2n; i++) begin
      r = {r[30:0], x[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// N x DW register file: one LANES-word write port, LANES combinational read ports.
// Latency: write visible on the cycle after we_i; reads are combinational.
// Backpressure: none; the caller owns bank occupancy.
// Ports: clk; we_i/wbase_i/wdat_i write LANES words at wbase_i..wbase_i+LANES-1;
//        raddr_i/rdat_o are LANES independent read ports.
module reorder_bank
  import fft_pkg::*;
#(
  parameter int DW    = 15,
  parameter int LOG2N = 5
) (
  input  logic                            clk,
  input  logic                            we_i,
  input  logic [LOG2N-1:0]                wbase_i,
  input  logic [LANES-1:0][DW-1:0]        wdat_i,
  input  logic [LANES-1:0][LOG2N-1:0]     raddr_i,
  output logic [LANES-1:0][DW-1:0]        rdat_o
);

  localparam int N = 1 << LOG2N;

  // Contents are never reset: bank occupancy flags in the top make stale data unreachable.
  logic [DW-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int l = 0; l < LANES; l++) begin
        // wbase_i is always a multiple of LANES, so OR-ing the lane index is an add.
        mem_q[wbase_i | LOG2N'(l)] <= wdat_i[l];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      rdat_o[l] = mem_q[raddr_i[l]];
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// Bit-reversed to natural-order reorder after topfft, ping-pong over two N-word banks.
// Latency: last input beat at edge t -> out_sof/out_valid registered at edge t+1 (read side idle).
// Backpressure: none; input rate <= output rate, so frames stream back-to-back without stalls.
// Ports: clk, rst (async active-low); in0_up/in0_down/in1_up/in1_down = lanes 0..3,
//        in_valid, in_sof; out0..out3 natural bins 4k..4k+3, out_valid, out_sof, frame_err.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int DW    = 15,
  parameter int LOG2N = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in0_up,
  input  logic [DW-1:0] in0_down,
  input  logic [DW-1:0] in1_up,
  input  logic [DW-1:0] in1_down,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic [DW-1:0] out0,
  output logic [DW-1:0] out1,
  output logic [DW-1:0] out2,
  output logic [DW-1:0] out3,
  output logic          out_valid,
  output logic          out_sof,
  output logic          frame_err
);

  localparam int               BEATS = 1 << (LOG2N - 2);
  localparam logic [LOG2N-1:0] LAST  = LOG2N'(BEATS - 1);

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_FILL = 1'b1;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_RUN  = 1'b1;

  logic [0:0]                wr_state_q, wr_state_d;
  logic [LOG2N-1:0]          wcnt_q, wcnt_d;
  logic                      wbank_q, wbank_d;
  logic [1:0]                full_q, full_d;   // 1 = FULL, 0 = EMPTY, one bit per bank
  logic [0:0]                rd_state_q, rd_state_d;
  logic [LOG2N-1:0]          rcnt_q, rcnt_d;
  logic                      rbank_q, rbank_d;
  logic [LANES-1:0][DW-1:0]  out_q, out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_sof_q, out_sof_d;
  logic                      frame_err_q, frame_err_d;

  logic                      we_beat, set_full, clr_full, rd_emit;
  logic [LOG2N-1:0]          wr_beat, rd_beat, wbase;
  logic [LANES-1:0][DW-1:0]  wdat, rdat0, rdat1, rdat;
  logic [LANES-1:0][LOG2N-1:0] raddr;

  assign wdat  = {in1_down, in1_up, in0_down, in0_up};
  assign wbase = wr_beat << 2;

  // Write FSM: sof always (re)starts a frame at beat 0; a restart mid-frame flags an error.
  always_comb begin
    wr_state_d  = wr_state_q;
    wcnt_d      = wcnt_q;
    wbank_d     = wbank_q;
    we_beat     = 1'b0;
    wr_beat     = wcnt_q;
    set_full    = 1'b0;
    frame_err_d = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        if (wr_state_q == WR_FILL) frame_err_d = 1'b1;
        if (full_q[wbank_q]) begin
          // Writer would overwrite an unread frame: drop this one instead.
          frame_err_d = 1'b1;
          wr_state_d  = WR_IDLE;
          wcnt_d      = '0;
        end else begin
          we_beat = 1'b1;
          wr_beat = '0;
          if (LAST == '0) begin
            set_full   = 1'b1;
            wbank_d    = ~wbank_q;
            wr_state_d = WR_IDLE;
            wcnt_d     = '0;
          end else begin
            wr_state_d = WR_FILL;
            wcnt_d     = LOG2N'(1);
          end
        end
      end else if (wr_state_q == WR_FILL) begin
        we_beat = 1'b1;
        if (wcnt_q == LAST) begin
          set_full   = 1'b1;
          wbank_d    = ~wbank_q;
          wr_state_d = WR_IDLE;
          wcnt_d     = '0;
        end else begin
          wcnt_d = wcnt_q + LOG2N'(1);
        end
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  // Read FSM: emitting beat 0 straight from IDLE gives the one-cycle latency and,
  // after a frame ends, lets the next FULL bank start on the very next cycle.
  always_comb begin
    rd_state_d  = rd_state_q;
    rcnt_d      = rcnt_q;
    rbank_d     = rbank_q;
    rd_emit     = 1'b0;
    rd_beat     = rcnt_q;
    clr_full    = 1'b0;
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    if (rd_state_q == RD_RUN) begin
      rd_emit = 1'b1;
    end else if (full_q[rbank_q]) begin
      rd_emit = 1'b1;
      rd_beat = '0;
    end
    if (rd_emit) begin
      out_d       = rdat;
      out_valid_d = 1'b1;
      out_sof_d   = (rd_beat == '0);
      if (rd_beat == LAST) begin
        clr_full   = 1'b1;
        rbank_d    = ~rbank_q;
        rd_state_d = RD_IDLE;
        rcnt_d     = '0;
      end else begin
        rd_state_d = RD_RUN;
        rcnt_d     = rd_beat + LOG2N'(1);
      end
    end
  end

  // Set and clear always hit different banks under legal use.
  always_comb begin
    full_d = full_q;
    if (clr_full) full_d[rbank_q] = 1'b0;
    if (set_full) full_d[wbank_q] = 1'b1;
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      raddr[l] = LOG2N'(bitrev((32'(rd_beat) << 2) | 32'(l), LOG2N));
    end
  end

  assign rdat = rbank_q ? rdat1 : rdat0;

  reorder_bank #(.DW(DW), .LOG2N(LOG2N)) u_bank0 (
    .clk     (clk),
    .we_i    (we_beat & ~wbank_q),
    .wbase_i (wbase),
    .wdat_i  (wdat),
    .raddr_i (raddr),
    .rdat_o  (rdat0)
  );

  reorder_bank #(.DW(DW), .LOG2N(LOG2N)) u_bank1 (
    .clk     (clk),
    .we_i    (we_beat & wbank_q),
    .wbase_i (wbase),
    .wdat_i  (wdat),
    .raddr_i (raddr),
    .rdat_o  (rdat1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state_q  <= WR_IDLE;
      wcnt_q      <= '0;
      wbank_q     <= 1'b0;
      full_q      <= '0;
      rd_state_q  <= RD_IDLE;
      rcnt_q      <= '0;
      rbank_q     <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      wcnt_q      <= wcnt_d;
      wbank_q     <= wbank_d;
      full_q      <= full_d;
      rd_state_q  <= rd_state_d;
      rcnt_q      <= rcnt_d;
      rbank_q     <= rbank_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out0      = out_q[0];
  assign out1      = out_q[1];
  assign out2      = out_q[2];
  assign out3      = out_q[3];
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign frame_err = frame_err_q;

endmodule
